// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipelined-CPU inter-stage register.
//   pipe_state_t  occupancy of a stage register (empty / one word / head+skid)
//   RESET_PC_DEF  default PC loaded into the PC word on reset
//   bubble_bus()  builds the nop pattern: every field zero except the PC word
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // Upper bounds for bubble_bus(); callers truncate the result to their bus width.
    localparam int BUS_MAX = 4096;
    localparam int PC_MAX  = 64;

    // All-zero bus (Instr=0 decodes as nop) with pc placed in word pc_field.
    function automatic logic [BUS_MAX-1:0] bubble_bus(input logic [PC_MAX-1:0] pc,
                                                      input int pc_field,
                                                      input int field_w);
        logic [BUS_MAX-1:0] b;
        b = '0;
        for (int i = 0; i < PC_MAX; i++) begin
            if (i < field_w && (pc_field * field_w + i) < BUS_MAX)
                b[pc_field * field_w + i] = pc[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one storage entry of the stage register.
//   clk    in  clock
//   en_i   in  load enable
//   sel_i  in  0: load a_i, 1: load b_i (bubble / clear pattern)
//   a_i    in  normal load value
//   b_i    in  alternate load value
//   q_o    out stored entry
module pipe_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         en_i,
    input  logic         sel_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (en_i)
            q_o <= sel_i ? b_i : a_i;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready inter-stage register for the pipelined MIPS CPU.
// Carries NFIELDS words plus the A3 destination index, with an optional skid
// entry, synchronous flush (bubble insertion) and a saturating stall counter.
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake
//   in_bus, in_a3         incoming word (field k at [k*FIELD_W +: FIELD_W])
//   flush, flush_pc       squash contents, leave a bubble carrying flush_pc
//   out_valid/out_ready   downstream handshake
//   out_bus, out_a3       head entry
//   stall_cnt             saturating count of out_valid && !out_ready cycles
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                 NFIELDS  = 8,
    parameter int                 FIELD_W  = 32,
    parameter int                 A3_W     = 5,
    parameter int                 PC_FIELD = 1,
    parameter logic [FIELD_W-1:0] RESET_PC = FIELD_W'(RESET_PC_DEF),
    parameter int                 SKID     = 1,
    parameter int                 CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NFIELDS*FIELD_W-1:0] in_bus,
    input  logic [A3_W-1:0]            in_a3,
    input  logic                       flush,
    input  logic [FIELD_W-1:0]         flush_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NFIELDS*FIELD_W-1:0] out_bus,
    output logic [A3_W-1:0]            out_a3,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int BUS_W = NFIELDS * FIELD_W;
    localparam int ENT_W = BUS_W + A3_W;

    pipe_state_t        state_q, state_d;
    logic               in_xfer, out_xfer;
    logic               head_en, head_sel, head_from_skid, skid_en;
    logic [ENT_W-1:0]   head_q, skid_q, head_a, head_b;
    logic [FIELD_W-1:0] bub_pc;
    logic [CNT_W-1:0]   stall_cnt_q;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        head_en        = 1'b0;
        head_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (SKID != 0) begin
            case (state_q)
                ST_EMPTY: if (in_xfer) begin
                    state_d = ST_ONE;
                    head_en = 1'b1;
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_en = 1'b1;
                    end else if (in_xfer) begin
                        skid_en = 1'b1;
                        state_d = ST_FULL;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;   // head data left as-is
                    end
                end
                ST_FULL: if (out_xfer) begin
                    head_en        = 1'b1;
                    head_from_skid = 1'b1;
                    state_d        = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end else begin
            if (in_xfer) begin
                head_en = 1'b1;
                state_d = ST_ONE;
            end else if (out_xfer) begin
                state_d = ST_EMPTY;
            end
        end
        // Reset and flush override any handshake; a same-cycle in_xfer is dropped.
        if (reset || flush) begin
            state_d = ST_EMPTY;
            head_en = 1'b1;
            skid_en = reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // Both reset and flush load the nop pattern; only the PC differs.
    assign head_sel = reset | flush;
    assign bub_pc   = reset ? RESET_PC : flush_pc;
    assign head_b   = {{A3_W{1'b0}}, BUS_W'(bubble_bus(PC_MAX'(bub_pc), PC_FIELD, FIELD_W))};
    assign head_a   = head_from_skid ? skid_q : {in_a3, in_bus};

    pipe_entry #(.W(ENT_W)) u_head (
        .clk   (clk),
        .en_i  (head_en),
        .sel_i (head_sel),
        .a_i   (head_a),
        .b_i   (head_b),
        .q_o   (head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;

            // Registered ready: no combinational path from out_ready to in_ready.
            always_ff @(posedge clk) begin
                if (reset) rdy_q <= 1'b1;
                else       rdy_q <= (state_d != ST_FULL);
            end
            assign in_ready = rdy_q;

            pipe_entry #(.W(ENT_W)) u_skid (
                .clk   (clk),
                .en_i  (skid_en),
                .sel_i (reset),
                .a_i   ({in_a3, in_bus}),
                .b_i   ('0),
                .q_o   (skid_q)
            );
        end else begin : g_noskid
            logic unused_skid_en;
            assign unused_skid_en = skid_en;
            assign in_ready       = out_ready | ~out_valid;
            assign skid_q         = '0;
        end
    endgenerate

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (out_valid && !out_ready && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign out_bus   = head_q[BUS_W-1:0];
    assign out_a3    = head_q[ENT_W-1 -: A3_W];
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int NF    = 8;
    localparam int FW    = 32;
    localparam int AW    = 5;
    localparam int BUS_W = NF * FW;
    localparam int ENT_W = BUS_W + AW;
    localparam int PCF   = 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [BUS_W-1:0] in_bus = '0;
    logic [AW-1:0]    in_a3 = '0;
    logic             flush = 1'b0;
    logic [FW-1:0]    flush_pc = '0;
    logic             out_ready = 1'b0;

    logic [2:0]       ov, ir;
    logic [BUS_W-1:0] ob [3];
    logic [AW-1:0]    oa [3];
    logic [15:0]      sc0, sc1;
    logic [3:0]       sc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d0: skid, 16-bit counter; d1: no skid; d2: skid, 4-bit counter
    pipe_stage_skid #(.SKID(1), .CNT_W(16)) d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_bus(in_bus),
        .in_a3(in_a3), .flush(flush), .flush_pc(flush_pc), .out_valid(ov[0]),
        .out_ready(out_ready), .out_bus(ob[0]), .out_a3(oa[0]), .stall_cnt(sc0));
    pipe_stage_skid #(.SKID(0), .CNT_W(16)) d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_bus(in_bus),
        .in_a3(in_a3), .flush(flush), .flush_pc(flush_pc), .out_valid(ov[1]),
        .out_ready(out_ready), .out_bus(ob[1]), .out_a3(oa[1]), .stall_cnt(sc1));
    pipe_stage_skid #(.SKID(1), .CNT_W(4)) d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_bus(in_bus),
        .in_a3(in_a3), .flush(flush), .flush_pc(flush_pc), .out_valid(ov[2]),
        .out_ready(out_ready), .out_bus(ob[2]), .out_a3(oa[2]), .stall_cnt(sc2));

    // Reference model: a FIFO of accepted words (capacity 2 with skid, 1 without),
    // plus the last word shown at the head and a saturating stall count.
    logic [ENT_W-1:0] mq [3][2];
    int               mn [3];
    logic [ENT_W-1:0] mh [3];
    int               mc [3];
    int               cmax [3]  = '{65535, 65535, 15};
    int               mcap [3]  = '{2, 1, 2};
    bit               armed = 0;
    logic [FW-1:0]    pc = 32'h0000_3000;

    function automatic logic [ENT_W-1:0] bubble(input logic [FW-1:0] p);
        logic [ENT_W-1:0] b;
        b = '0;
        b[PCF*FW +: FW] = p;
        return b;
    endfunction

    function automatic int scnt(input int k);
        if (k == 0) return int'(sc0);
        if (k == 1) return int'(sc1);
        return int'(sc2);
    endfunction

    function automatic bit mready(input int k);
        if (mcap[k] == 2) return mn[k] < 2;
        return out_ready || mn[k] == 0;
    endfunction

    task automatic chk(input string tag, input logic [ENT_W-1:0] obs, input logic [ENT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k);
        bit vld, inx, outx;
        if (reset) begin
            mn[k] = 0;
            mh[k] = bubble(32'h0000_3000);
            mc[k] = 0;
            return;
        end
        vld  = mn[k] > 0;
        inx  = in_valid && mready(k);
        outx = vld && out_ready;
        if (vld && !out_ready && mc[k] < cmax[k]) mc[k]++;
        if (flush) begin
            mn[k] = 0;
            mh[k] = bubble(flush_pc);
        end else begin
            if (outx) begin
                mq[k][0] = mq[k][1];
                mn[k]--;
            end
            if (inx) begin
                mq[k][mn[k]] = {in_a3, in_bus};
                mn[k]++;
            end
            if (mn[k] > 0) mh[k] = mq[k][0];
        end
    endtask

    // Compare at the falling edge, then advance the model to the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d_valid", k), ENT_W'(ov[k]), ENT_W'(mn[k] > 0));
                chk($sformatf("d%0d_ready", k), ENT_W'(ir[k]), ENT_W'(mready(k)));
                chk($sformatf("d%0d_head", k), {oa[k], ob[k]}, mh[k]);
                chk($sformatf("d%0d_stall", k), ENT_W'(scnt(k)), ENT_W'(mc[k]));
            end
        end
        for (int k = 0; k < 3; k++) model_step(k);
        if (reset) armed = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic new_word();
        for (int f = 0; f < NF; f++) in_bus[f*FW +: FW] = $urandom;
        in_bus[PCF*FW +: FW] = pc;
        in_a3 = AW'($urandom);
        pc = pc + 32'd4;
    endtask

    task automatic drive(input bit v, input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = v;
            out_ready = r;
            new_word();
            cycle();
        end
    endtask

    initial begin
        // reset for two cycles
        reset = 1'b1;
        drive(1, 0, 2);
        reset = 1'b0;
        chk("rst_valid", ENT_W'(ov[0]), '0);
        chk("rst_pc", ENT_W'(ob[0][PCF*FW +: FW]), ENT_W'(32'h0000_3000));
        chk("rst_instr", ENT_W'(ob[0][FW-1:0]), '0);
        chk("rst_a3", ENT_W'(oa[0]), '0);
        chk("rst_stall", ENT_W'(sc0), '0);
        chk("rst_ready", ENT_W'(ir), ENT_W'(3'b111));

        // streaming at full rate
        pc = 32'h0000_3000;
        drive(1, 1, 10);
        chk("stream_stall", ENT_W'(sc0), '0);

        // backpressure for 3 cycles, then drain
        drive(1, 0, 1);
        chk("bp_ready_d0", ENT_W'(ir[0]), '0);
        drive(1, 0, 2);
        chk("bp_stall_d0", ENT_W'(sc0), ENT_W'(16'd3));
        drive(0, 1, 3);

        // fill head and skid, then flush with a new word offered
        drive(1, 0, 2);
        flush = 1'b1;
        flush_pc = 32'h0000_3040;
        drive(1, 0, 1);
        flush = 1'b0;
        chk("fl_valid", ENT_W'(ov[0]), '0);
        chk("fl_pc", ENT_W'(ob[0][PCF*FW +: FW]), ENT_W'(32'h0000_3040));
        chk("fl_instr", ENT_W'(ob[0][FW-1:0]), '0);
        chk("fl_a3", ENT_W'(oa[0]), '0);
        drive(1, 1, 4);

        // ready toggle 1,0,1
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 1, 1);
        drive(0, 1, 2);

        // counter saturation on the 4-bit instance, then reset mid-stall
        drive(1, 0, 1);
        drive(0, 0, 20);
        chk("sat_cnt4", ENT_W'(sc2), ENT_W'(4'd15));
        drive(0, 0, 2);
        chk("sat_hold", ENT_W'(sc2), ENT_W'(4'd15));
        reset = 1'b1;
        drive(0, 0, 1);
        reset = 1'b0;
        chk("sat_rst", ENT_W'(sc2), '0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 31) == 0);
            flush_pc = $urandom;
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), 1);
        end
        reset = 1'b0;
        flush = 1'b0;
        drive(0, 1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
